// File: rtl/beat_sequence_monitor_if.sv
// Beat-bus monitor signal bundle: stimulus side (t, clr, optional hold) and status side.
// The hold line exists only when BEAT_MON_HOLD_EN is defined.
interface beat_sequence_monitor_if #(
  parameter int BEATS = 4,
  parameter int CNT_W = 16
);
  localparam int PH_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEATS-1:0] t;
  logic             clr;
`ifdef BEAT_MON_HOLD_EN
  logic             hold;
`endif
  logic             locked;
  logic [PH_W-1:0]  phase;
  logic             cycle_done;
  logic [CNT_W-1:0] cycle_cnt;
  logic             err_onehot;
  logic             err_order;
  logic [7:0]       err_cnt;

`ifdef BEAT_MON_HOLD_EN
  modport master (
    output t, clr, hold,
    input  locked, phase, cycle_done, cycle_cnt, err_onehot, err_order, err_cnt
  );
  modport slave (
    input  t, clr, hold,
    output locked, phase, cycle_done, cycle_cnt, err_onehot, err_order, err_cnt
  );
`else
  modport master (
    output t, clr,
    input  locked, phase, cycle_done, cycle_cnt, err_onehot, err_order, err_cnt
  );
  modport slave (
    input  t, clr,
    output locked, phase, cycle_done, cycle_cnt, err_onehot, err_order, err_cnt
  );
`endif
endinterface

// File: rtl/beat_sequence_monitor.sv
// Receive-side checker for the one-hot beat rotation: lock tracking, phase, cycle and error counts.
// Define BEAT_MON_HOLD_EN to add the hold input that lets a beat legally repeat.
module beat_sequence_monitor #(
  parameter int BEATS       = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  beat_sequence_monitor_if.slave   bus
);

  localparam int PH_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GOOD_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [BEATS-1:0] FIRST_BEAT = BEATS'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BEATS-1:0] prev_q, prev_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             locked_q, locked_d;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_order_q, err_order_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [BEATS-1:0] expected;
  logic             advance;
  logic             err;

  function automatic logic [PH_W-1:0] beat_index(input logic [BEATS-1:0] beat);
    logic [PH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat[i]) idx = PH_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned (no latch).
    state_d      = state_q;
    prev_d       = prev_q;
    good_d       = good_q;
    phase_d      = phase_q;
    cycle_done_d = 1'b0;
    cycle_cnt_d  = bus.clr ? '0 : cycle_cnt_q;
    err_onehot_d = bus.clr ? 1'b0 : err_onehot_q;
    err_order_d  = bus.clr ? 1'b0 : err_order_q;
    err_cnt_d    = bus.clr ? 8'd0 : err_cnt_q;
    err          = 1'b0;
    expected     = {prev_q[BEATS-2:0], prev_q[BEATS-1]};
    advance      = 1'b1;
`ifdef BEAT_MON_HOLD_EN
    if (bus.hold) begin
      expected = prev_q;
      advance  = 1'b0;
    end
`endif

    unique case (state_q)
      HUNT: begin
        if (bus.t == FIRST_BEAT) begin
          prev_d  = bus.t;
          good_d  = '0;
          phase_d = '0;
          state_d = TRACK;
        end
      end
      default: begin
        // One-hot violations take priority so a single sample is never counted twice.
        if (!$onehot(bus.t)) begin
          err_onehot_d = 1'b1;
          err          = 1'b1;
        end else if (bus.t != expected) begin
          err_order_d = 1'b1;
          err         = 1'b1;
        end else begin
          prev_d  = bus.t;
          phase_d = beat_index(bus.t);
          if (advance && prev_q[BEATS-1]) begin
            cycle_done_d = 1'b1;
            if (cycle_cnt_d != '1) cycle_cnt_d = cycle_cnt_d + 1'b1;
            if (state_q == TRACK) begin
              good_d = good_q + 1'b1;
              if (good_d == GOOD_W'(LOCK_CYCLES)) state_d = LOCKED;
            end
          end
        end

        if (err) begin
          if (err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 1'b1;
          state_d = HUNT;
          prev_d  = '0;
          good_d  = '0;
          phase_d = '0;
        end
      end
    endcase

    locked_d = (state_d == LOCKED);
  end

  // NOTE: state is updated only here, with non-blocking assignments, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      prev_q       <= '0;
      good_q       <= '0;
      phase_q      <= '0;
      locked_q     <= 1'b0;
      cycle_done_q <= 1'b0;
      cycle_cnt_q  <= '0;
      err_onehot_q <= 1'b0;
      err_order_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      phase_q      <= phase_d;
      locked_q     <= locked_d;
      cycle_done_q <= cycle_done_d;
      cycle_cnt_q  <= cycle_cnt_d;
      err_onehot_q <= err_onehot_d;
      err_order_q  <= err_order_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.phase      = phase_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.err_onehot = err_onehot_q;
  assign bus.err_order  = err_order_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_beat_sequence_monitor.sv
// Directed bench for beat_sequence_monitor: vector table plus hand-written reset, saturation and stall cases.
// Builds with or without BEAT_MON_HOLD_EN; the stall case checks whichever behaviour is compiled in.
module tb_beat_sequence_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  beat_sequence_monitor_if #(.BEATS(4), .CNT_W(4)) bus ();

  beat_sequence_monitor #(.BEATS(4), .CNT_W(4), .LOCK_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] t;
    logic       clr;
    logic       lk;
    logic [1:0] ph;
    logic       cd;
    logic [3:0] cc;
    logic       eo;
    logic       er;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] t, input logic clr, input logic lk,
                              input logic [1:0] ph, input logic cd, input logic [3:0] cc,
                              input logic eo, input logic er, input logic [7:0] ec);
    vec_t v;
    v = '{t, clr, lk, ph, cd, cc, eo, er, ec};
    vecs.push_back(v);
  endfunction

  function automatic logic [17:0] outs();
    return {bus.locked, bus.phase, bus.cycle_done, bus.cycle_cnt,
            bus.err_onehot, bus.err_order, bus.err_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] t, input logic clr);
    @(negedge clk);
    bus.t   = t;
    bus.clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    bus.t   = 4'd0;
    bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rotate(input int n);
    for (int i = 0; i < n; i++) begin
      step(4'b0010, 1'b0);
      step(4'b0100, 1'b0);
      step(4'b1000, 1'b0);
      step(4'b0001, 1'b0);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    bus.t   = 4'd0;
    bus.clr = 1'b0;
`ifdef BEAT_MON_HOLD_EN
    bus.hold = 1'b0;
`endif

    // Clean run: lock after the second wrap, then five wraps total.
    add(4'h1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'h2, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4'h4, 0, 0, 2, 0, 0, 0, 0, 0);
    add(4'h8, 0, 0, 3, 0, 0, 0, 0, 0);
    add(4'h1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(4'h2, 0, 0, 1, 0, 1, 0, 0, 0);
    add(4'h4, 0, 0, 2, 0, 1, 0, 0, 0);
    add(4'h8, 0, 0, 3, 0, 1, 0, 0, 0);
    add(4'h1, 0, 1, 0, 1, 2, 0, 0, 0);
    add(4'h2, 0, 1, 1, 0, 2, 0, 0, 0);
    add(4'h4, 0, 1, 2, 0, 2, 0, 0, 0);
    add(4'h8, 0, 1, 3, 0, 2, 0, 0, 0);
    add(4'h1, 0, 1, 0, 1, 3, 0, 0, 0);
    add(4'h2, 0, 1, 1, 0, 3, 0, 0, 0);
    add(4'h4, 0, 1, 2, 0, 3, 0, 0, 0);
    add(4'h8, 0, 1, 3, 0, 3, 0, 0, 0);
    add(4'h1, 0, 1, 0, 1, 4, 0, 0, 0);
    add(4'h2, 0, 1, 1, 0, 4, 0, 0, 0);
    add(4'h4, 0, 1, 2, 0, 4, 0, 0, 0);
    add(4'h8, 0, 1, 3, 0, 4, 0, 0, 0);
    add(4'h1, 0, 1, 0, 1, 5, 0, 0, 0);
    // Order fault, then relock from 0001 plus two clean rotations.
    add(4'h2, 0, 1, 1, 0, 5, 0, 0, 0);
    add(4'h8, 0, 0, 0, 0, 5, 0, 1, 1);
    add(4'h1, 0, 0, 0, 0, 5, 0, 1, 1);
    add(4'h2, 0, 0, 1, 0, 5, 0, 1, 1);
    add(4'h4, 0, 0, 2, 0, 5, 0, 1, 1);
    add(4'h8, 0, 0, 3, 0, 5, 0, 1, 1);
    add(4'h1, 0, 0, 0, 1, 6, 0, 1, 1);
    add(4'h2, 0, 0, 1, 0, 6, 0, 1, 1);
    add(4'h4, 0, 0, 2, 0, 6, 0, 1, 1);
    add(4'h8, 0, 0, 3, 0, 6, 0, 1, 1);
    add(4'h1, 0, 1, 0, 1, 7, 0, 1, 1);
    // clr while locked, then one-hot fault, then idle in HUNT.
    add(4'h2, 1, 1, 1, 0, 0, 0, 0, 0);
    add(4'h6, 0, 0, 0, 0, 0, 1, 0, 1);
    add(4'h0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(4'h0, 0, 0, 0, 0, 0, 1, 0, 1);
    // clr coincident with order fault, clr alone, clr with a wrap.
    add(4'h1, 0, 0, 0, 0, 0, 1, 0, 1);
    add(4'h2, 0, 0, 1, 0, 0, 1, 0, 1);
    add(4'h4, 0, 0, 2, 0, 0, 1, 0, 1);
    add(4'h8, 0, 0, 3, 0, 0, 1, 0, 1);
    add(4'h1, 0, 0, 0, 1, 1, 1, 0, 1);
    add(4'h4, 1, 0, 0, 0, 0, 0, 1, 1);
    add(4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(4'h1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'h2, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4'h4, 0, 0, 2, 0, 0, 0, 0, 0);
    add(4'h8, 0, 0, 3, 0, 0, 0, 0, 0);
    add(4'h1, 1, 0, 0, 1, 1, 0, 0, 0);
    add(4'h2, 1, 0, 1, 0, 0, 0, 0, 0);
    add(4'h4, 0, 0, 2, 0, 0, 0, 0, 0);
    add(4'h8, 0, 0, 3, 0, 0, 0, 0, 0);
    add(4'h1, 0, 1, 0, 1, 1, 0, 0, 0);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].t, vecs[i].clr);
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].lk, vecs[i].ph, vecs[i].cd, vecs[i].cc,
                 vecs[i].eo, vecs[i].er, vecs[i].ec}));
    end

    // Async reset pulse mid-cycle while locked at phase 2.
    do_reset();
    step(4'b0001, 1'b0);
    rotate(2);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    check("pre_async_locked", 32'(bus.locked), 32'd1);
    check("pre_async_phase", 32'(bus.phase), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("async_outs_during", 32'(outs()), 32'd0);
    rst = 1'b1;
    #2;
    check("async_outs_after", 32'(outs()), 32'd0);
    step(4'b1000, 1'b0);
    check("async_hunt_ignores", 32'(outs()), 32'd0);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    check("async_retrack_phase", 32'(bus.phase), 32'd1);

    // Saturation of both counters.
    do_reset();
    step(4'b0001, 1'b0);
    rotate(15);
    check("cnt_at_15", 32'(bus.cycle_cnt), 32'd15);
    rotate(5);
    check("cnt_saturated", 32'(bus.cycle_cnt), 32'd15);
    check("cnt_sat_locked", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 300; i++) begin
      step(4'b0001, 1'b0);
      step(4'b0011, 1'b0);
    end
    check("err_cnt_saturated", 32'(bus.err_cnt), 32'd255);
    check("err_onehot_after_faults", 32'(bus.err_onehot), 32'd1);
    check("cnt_kept_after_faults", 32'(bus.cycle_cnt), 32'd15);

    // Stalled beat at phase 2 while locked.
    do_reset();
    step(4'b0001, 1'b0);
    rotate(2);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
`ifdef BEAT_MON_HOLD_EN
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0);
      check($sformatf("hold%0d", i), 32'(outs()),
            32'({1'b1, 2'd2, 1'b0, 4'd2, 1'b0, 1'b0, 8'd0}));
    end
    bus.hold = 1'b0;
    step(4'b1000, 1'b0);
    check("hold_resume_phase", 32'(bus.phase), 32'd3);
    step(4'b0001, 1'b0);
    check("hold_resume_wrap", 32'(outs()),
          32'({1'b1, 2'd0, 1'b1, 4'd3, 1'b0, 1'b0, 8'd0}));
    bus.hold = 1'b1;
    step(4'b0010, 1'b0);
    check("hold_wrong_beat", 32'(outs()),
          32'({1'b0, 2'd0, 1'b0, 4'd3, 1'b0, 1'b1, 8'd1}));
    bus.hold = 1'b0;
`else
    step(4'b0100, 1'b0);
    check("stall_order_err", 32'(outs()),
          32'({1'b0, 2'd0, 1'b0, 4'd2, 1'b0, 1'b1, 8'd1}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
